// File: rtl/rf68000_ring_server.sv
// Ring node that turns addressed read/write request packets into bus master
// cycles and returns acknowledge/error packets on the response ring.
package rf68000_ring_pkg;
  typedef enum logic [3:0] {
    PT_NULL  = 4'd0,
    PT_READ  = 4'd1,
    PT_WRITE = 4'd2,
    PT_AREAD = 4'd3,
    PT_ACK   = 4'd4,
    PT_AACK  = 4'd5,
    PT_ERR   = 4'd6,
    PT_VPA   = 4'd7
  } pkt_typ_e;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [5:0]  age;
    logic        ack;
    pkt_typ_e    typ;
    logic [3:0]  sel;
    logic [7:0]  asid;
    logic [2:0]  fc;
    logic        mmus;
    logic        ios;
    logic        iops;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;
endpackage

module rf68000_ring_server
  import rf68000_ring_pkg::*;
#(
  parameter logic [5:0] NODE_ID    = 6'd62,
  parameter int         FIFO_DEPTH = 4,
  parameter bit         SYNC_WRITE = 1'b1,
  parameter int         TO_BITS    = 12
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  packet_t                         packet_i,
  output packet_t                         packet_o,
  input  packet_t                         rpacket_i,
  output packet_t                         rpacket_o,
  output logic                            m_cyc_o,
  output logic                            m_stb_o,
  output logic                            m_we_o,
  output logic [3:0]                      m_sel_o,
  output logic [7:0]                      m_asid_o,
  output logic [2:0]                      m_fc_o,
  output logic [31:0]                     m_adr_o,
  output logic [31:0]                     m_dat_o,
  output logic                            m_mmus_o,
  output logic                            m_ios_o,
  output logic                            m_iops_o,
  input  logic                            m_ack_i,
  input  logic                            m_err_i,
  input  logic                            m_vpa_i,
  input  logic [31:0]                     m_dat_i,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Terminate on the edge where the counter would step onto all-ones.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;

  state_e             state_q, state_d;
  packet_t            fifo_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;
  packet_t            cur_q, rsp_q, rsp_d, pkt_d, head;
  logic               rsp_vld_q;
  logic [TO_BITS-1:0] to_q;
  packet_t            pkt_q, rpkt_q;
  logic               cyc_q, stb_q, we_q, mmus_q, ios_q, iops_q;
  logic [3:0]         sel_q;
  logic [7:0]         asid_q;
  logic [2:0]         fc_q;
  logic [31:0]        adr_q, dat_q;

  logic     hit, is_req, full, push, pop, term, send_rsp, rsp_fwd;
  pkt_typ_e rsp_typ;

  assign head   = fifo_q[rd_q];
  assign hit    = (packet_i.did == NODE_ID);
  assign is_req = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD) ||
                  (packet_i.typ == PT_WRITE);
  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign push   = hit && is_req && !full;

  // A full queue leaves addressed requests on the ring for a later lap.
  always_comb begin
    pkt_d = packet_i;
    if (hit && !(is_req && full)) pkt_d.did = '0;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    term     = 1'b0;
    send_rsp = 1'b0;
    rsp_fwd  = 1'b0;
    rsp_typ  = PT_NULL;
    case (state_q)
      IDLE: if (cnt_q != '0 && !rsp_vld_q) begin
        pop     = 1'b1;
        state_d = BUS;
      end
      BUS: begin
        if (m_ack_i) begin
          term    = 1'b1;
          rsp_typ = (cur_q.typ == PT_AREAD) ? PT_AACK : PT_ACK;
        end else if (m_err_i) begin
          term    = 1'b1;
          rsp_typ = PT_ERR;
        end else if (m_vpa_i) begin
          term    = 1'b1;
          rsp_typ = PT_VPA;
        end else if (to_q == TO_LAST) begin
          term    = 1'b1;
          rsp_typ = PT_ERR;
        end
        if (term) begin
          if (cur_q.typ == PT_WRITE && !SYNC_WRITE) state_d = IDLE;
          else begin
            send_rsp = 1'b1;
            state_d  = RSP;
          end
        end
      end
      RSP: if (rpacket_i.did == '0) begin
        rsp_fwd = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_d      = '0;
    rsp_d.sid  = NODE_ID;
    rsp_d.did  = cur_q.sid;
    rsp_d.ack  = 1'b1;
    rsp_d.typ  = rsp_typ;
    rsp_d.adr  = cur_q.adr;
    rsp_d.dat  = m_dat_i;
    rsp_d.asid = cur_q.asid;
    rsp_d.mmus = cur_q.mmus;
    rsp_d.ios  = cur_q.ios;
    rsp_d.iops = cur_q.iops;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= packet_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      rpkt_q    <= '0;
      cur_q     <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      rpkt_q  <= rsp_fwd ? rsp_q : rpacket_i;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q  <= rd_q + 1'b1;
        cur_q <= head;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (send_rsp) begin
        rsp_q     <= rsp_d;
        rsp_vld_q <= 1'b1;
      end else if (rsp_fwd) begin
        rsp_vld_q <= 1'b0;
      end
      to_q <= (!cyc_q || term) ? '0 : to_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      asid_q <= '0;
      fc_q   <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      mmus_q <= 1'b0;
      ios_q  <= 1'b0;
      iops_q <= 1'b0;
    end else if (pop) begin
      cyc_q  <= 1'b1;
      stb_q  <= 1'b1;
      we_q   <= (head.typ == PT_WRITE);
      sel_q  <= head.sel;
      asid_q <= head.asid;
      fc_q   <= head.fc;
      adr_q  <= head.adr;
      dat_q  <= head.dat;
      mmus_q <= head.mmus;
      ios_q  <= head.ios;
      iops_q <= head.iops;
    end else if (term) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      fc_q   <= '0;
      mmus_q <= 1'b0;
      ios_q  <= 1'b0;
      iops_q <= 1'b0;
    end
  end

  assign packet_o     = pkt_q;
  assign rpacket_o    = rpkt_q;
  assign m_cyc_o      = cyc_q;
  assign m_stb_o      = stb_q;
  assign m_we_o       = we_q;
  assign m_sel_o      = sel_q;
  assign m_asid_o     = asid_q;
  assign m_fc_o       = fc_q;
  assign m_adr_o      = adr_q;
  assign m_dat_o      = dat_q;
  assign m_mmus_o     = mmus_q;
  assign m_ios_o      = ios_q;
  assign m_iops_o     = iops_q;
  assign fifo_count_o = cnt_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_rf68000_ring_server.sv
// Directed bench for rf68000_ring_server: a synchronous-write node (u_dut)
// and a posted-write node (u_post) share the clock and reset.
module tb_rf68000_ring_server;
  import rf68000_ring_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  packet_t     pkt_i, pkt_o, rpkt_i, rpkt_o;
  logic        cyc, stb, we, mmus, ios, iops, ack, err, vpa;
  logic [3:0]  sel;
  logic [7:0]  asid;
  logic [2:0]  fc;
  logic [31:0] adr, dato, dati;
  logic [2:0]  fcnt;
  logic        busy;

  packet_t     p_pkt_i, p_pkt_o, p_rpkt_o;
  logic        p_cyc, p_stb, p_we, p_mmus, p_ios, p_iops, p_ack, p_busy;
  logic [3:0]  p_sel;
  logic [7:0]  p_asid;
  logic [2:0]  p_fc, p_fcnt;
  logic [31:0] p_adr, p_dato;

  rf68000_ring_server u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .packet_i(pkt_i), .packet_o(pkt_o), .rpacket_i(rpkt_i), .rpacket_o(rpkt_o),
    .m_cyc_o(cyc), .m_stb_o(stb), .m_we_o(we), .m_sel_o(sel), .m_asid_o(asid),
    .m_fc_o(fc), .m_adr_o(adr), .m_dat_o(dato), .m_mmus_o(mmus), .m_ios_o(ios),
    .m_iops_o(iops), .m_ack_i(ack), .m_err_i(err), .m_vpa_i(vpa), .m_dat_i(dati),
    .fifo_count_o(fcnt), .busy_o(busy)
  );

  rf68000_ring_server #(.SYNC_WRITE(1'b0)) u_post (
    .clk_i(clk), .rst_ni(rst_n),
    .packet_i(p_pkt_i), .packet_o(p_pkt_o), .rpacket_i('0), .rpacket_o(p_rpkt_o),
    .m_cyc_o(p_cyc), .m_stb_o(p_stb), .m_we_o(p_we), .m_sel_o(p_sel),
    .m_asid_o(p_asid), .m_fc_o(p_fc), .m_adr_o(p_adr), .m_dat_o(p_dato),
    .m_mmus_o(p_mmus), .m_ios_o(p_ios), .m_iops_o(p_iops), .m_ack_i(p_ack),
    .m_err_i(1'b0), .m_vpa_i(1'b0), .m_dat_i(32'h0),
    .fifo_count_o(p_fcnt), .busy_o(p_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk(input logic [5:0] did, input logic [5:0] sid,
                                 input pkt_typ_e typ, input logic [31:0] a,
                                 input logic [31:0] d);
    packet_t p;
    p      = '0;
    p.did  = did;
    p.sid  = sid;
    p.typ  = typ;
    p.adr  = a;
    p.dat  = d;
    p.sel  = 4'hF;
    p.asid = 8'h11;
    p.fc   = 3'd5;
    p.ios  = 1'b1;
    return p;
  endfunction

  // Issue one request into an idle node, terminate it, and check the response type.
  task automatic run_req(input string tag, input pkt_typ_e typ, input logic a,
                         input logic e, input logic v, input pkt_typ_e exp);
    pkt_i = mk(6'd62, 6'd4, typ, 32'h0000_2000, 32'h0);
    tick;
    pkt_i = '0;
    tick;
    chk({tag, "_cyc"}, 128'(cyc), 128'(1));
    ack = a; err = e; vpa = v; dati = 32'hCAFE_0001;
    tick;
    ack = 0; err = 0; vpa = 0;
    tick;
    chk({tag, "_typ"}, 128'(rpkt_o.typ), 128'(exp));
    chk({tag, "_did"}, 128'(rpkt_o.did), 128'(4));
  endtask

  initial begin
    packet_t busy_pkt;
    int n;
    pkt_i = '0; rpkt_i = '0; p_pkt_i = '0; p_ack = 0;
    ack = 0; err = 0; vpa = 0; dati = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cyc", 128'(cyc), 128'(0));
    chk("rst_fcnt", 128'(fcnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pkt_o", 128'(pkt_o), 128'(0));
    chk("rst_rpkt_o", 128'(rpkt_o), 128'(0));
    tick; tick;
    rst_n = 1'b1;

    // Read with ack two cycles into the bus cycle.
    pkt_i = mk(6'd62, 6'd3, PT_READ, 32'h4000_0010, 32'h0);
    tick;
    pkt_i = '0;
    chk("rd_pkt_did0", 128'(pkt_o.did), 128'(0));
    chk("rd_pkt_typ", 128'(pkt_o.typ), 128'(PT_READ));
    chk("rd_fcnt1", 128'(fcnt), 128'(1));
    tick;
    chk("rd_cyc", 128'(cyc), 128'(1));
    chk("rd_we", 128'(we), 128'(0));
    chk("rd_adr", 128'(adr), 128'(32'h4000_0010));
    chk("rd_sel", 128'(sel), 128'(4'hF));
    chk("rd_fc", 128'(fc), 128'(5));
    chk("rd_fcnt0", 128'(fcnt), 128'(0));
    chk("rd_busy", 128'(busy), 128'(1));
    tick;
    ack = 1; dati = 32'h1234_5678;
    tick;
    ack = 0;
    chk("rd_cyc_drop", 128'(cyc), 128'(0));
    chk("rd_sel_zero", 128'(sel), 128'(0));
    tick;
    chk("rd_rsp_typ", 128'(rpkt_o.typ), 128'(PT_ACK));
    chk("rd_rsp_did", 128'(rpkt_o.did), 128'(3));
    chk("rd_rsp_sid", 128'(rpkt_o.sid), 128'(62));
    chk("rd_rsp_dat", 128'(rpkt_o.dat), 128'(32'h1234_5678));
    chk("rd_rsp_adr", 128'(rpkt_o.adr), 128'(32'h4000_0010));
    chk("rd_rsp_ack", 128'(rpkt_o.ack), 128'(1));
    chk("rd_rsp_asid", 128'(rpkt_o.asid), 128'(8'h11));
    chk("rd_busy_end", 128'(busy), 128'(0));

    // Overflow: w0 holds the bus, w1..w4 fill the queue, w5 must pass through.
    for (int i = 0; i < 6; i++) begin
      pkt_i = mk(6'd62, 6'd8, PT_WRITE, 32'h100 + 32'(i), 32'hD0 + 32'(i));
      tick;
    end
    pkt_i = '0;
    chk("ovf_fcnt4", 128'(fcnt), 128'(4));
    chk("ovf_pass_did", 128'(pkt_o.did), 128'(62));
    chk("ovf_pass_adr", 128'(pkt_o.adr), 128'(32'h105));
    chk("ovf_bus_adr", 128'(adr), 128'(32'h100));
    chk("ovf_we", 128'(we), 128'(1));
    ack = 1;
    tick;
    ack = 0;
    tick;
    chk("wr_rsp_typ", 128'(rpkt_o.typ), 128'(PT_ACK));
    chk("wr_rsp_did", 128'(rpkt_o.did), 128'(8));
    tick;
    chk("ovf_drain_fcnt", 128'(fcnt), 128'(3));
    chk("ovf_drain_adr", 128'(adr), 128'(32'h101));
    pkt_i = mk(6'd62, 6'd8, PT_WRITE, 32'h105, 32'hD5);
    tick;
    pkt_i = '0;
    chk("ovf_retry_did", 128'(pkt_o.did), 128'(0));
    chk("ovf_retry_fcnt", 128'(fcnt), 128'(4));

    // Asynchronous reset in the middle of a bus cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 128'(cyc), 128'(0));
    chk("arst_fcnt", 128'(fcnt), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    tick;
    rst_n = 1'b1;

    // Response ring occupied for 10 cycles after the ack.
    pkt_i = mk(6'd62, 6'd7, PT_READ, 32'h0000_0700, 32'h0);
    tick;
    pkt_i = '0;
    tick;
    busy_pkt = mk(6'd5, 6'd1, PT_ACK, 32'h55, 32'h66);
    ack = 1; dati = 32'hAAAA_5555; rpkt_i = busy_pkt;
    tick;
    ack = 0;
    pkt_i = mk(6'd62, 6'd9, PT_READ, 32'h0000_0ABC, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick;
      pkt_i = '0;
      chk("rb_pass", 128'(rpkt_o), 128'(busy_pkt));
    end
    chk("rb_hold_busy", 128'(busy), 128'(1));
    chk("rb_hold_cyc", 128'(cyc), 128'(0));
    chk("rb_fcnt", 128'(fcnt), 128'(1));
    rpkt_i = '0;
    tick;
    chk("rb_rsp_typ", 128'(rpkt_o.typ), 128'(PT_ACK));
    chk("rb_rsp_did", 128'(rpkt_o.did), 128'(7));
    chk("rb_cyc_after", 128'(cyc), 128'(0));
    tick;
    chk("rb_next_cyc", 128'(cyc), 128'(1));
    chk("rb_next_adr", 128'(adr), 128'(32'h0000_0ABC));

    // No termination: the bus cycle times out.
    n = 1;
    while (cyc && n < 5000) begin
      tick;
      if (cyc) n++;
    end
    chk("to_cycles", 128'(n), 128'(4095));
    tick;
    chk("to_rsp_typ", 128'(rpkt_o.typ), 128'(PT_ERR));
    chk("to_rsp_adr", 128'(rpkt_o.adr), 128'(32'h0000_0ABC));
    chk("to_rsp_did", 128'(rpkt_o.did), 128'(9));

    // Non-request traffic at this node is discarded; broadcasts and others pass.
    pkt_i = mk(6'd62, 6'd2, PT_ACK, 32'h1, 32'h2);
    tick;
    chk("disc_did", 128'(pkt_o.did), 128'(0));
    chk("disc_fcnt", 128'(fcnt), 128'(0));
    pkt_i = mk(6'd63, 6'd2, PT_READ, 32'h3, 32'h4);
    tick;
    chk("bcast_pass", 128'(pkt_o), 128'(mk(6'd63, 6'd2, PT_READ, 32'h3, 32'h4)));
    pkt_i = mk(6'd10, 6'd2, PT_WRITE, 32'h5, 32'h6);
    tick;
    chk("other_pass", 128'(pkt_o), 128'(mk(6'd10, 6'd2, PT_WRITE, 32'h5, 32'h6)));
    chk("other_fcnt", 128'(fcnt), 128'(0));
    pkt_i = '0;
    tick;

    // Termination priority.
    run_req("pri_ack_err", PT_READ, 1'b1, 1'b1, 1'b0, PT_ACK);
    run_req("aread_ack", PT_AREAD, 1'b1, 1'b0, 1'b0, PT_AACK);
    run_req("err_vpa", PT_READ, 1'b0, 1'b1, 1'b1, PT_ERR);
    run_req("vpa_only", PT_READ, 1'b0, 1'b0, 1'b1, PT_VPA);

    // Posted write on the SYNC_WRITE=0 node.
    p_pkt_i = mk(6'd62, 6'd6, PT_WRITE, 32'h0000_0900, 32'h0000_00EE);
    tick;
    p_pkt_i = '0;
    tick;
    chk("post_cyc", 128'(p_cyc), 128'(1));
    chk("post_we", 128'(p_we), 128'(1));
    chk("post_dat", 128'(p_dato), 128'(32'hEE));
    p_ack = 1;
    tick;
    p_ack = 0;
    chk("post_cyc_drop", 128'(p_cyc), 128'(0));
    chk("post_idle", 128'(p_busy), 128'(0));
    tick;
    chk("post_no_rsp", 128'(p_rpkt_o), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
